// File: rtl/huff_pkg.sv
// huff_pkg: constants, code-table entry type and the fixed symbol -> prefix
// code table shared by the encoder (and the matching decoder).
//
// Each code is stored LSB-first: bit0 is the first bit on the wire.
//   0      -> 0
//   +/-k   -> k ones, a 0, then the sign (0 = +, 1 = -); lengths 3..9
//   -8     -> eight ones (no terminator, length 8)
package huff_pkg;

  localparam int MAX_CODE = 9;   // longest code in bits
  localparam int BUF_W    = 16;  // accumulator width, >= MAX_CODE + 4
  localparam int CHUNK_W  = 4;   // largest output chunk in bits

  typedef struct packed {
    logic [MAX_CODE-1:0] code;
    logic [3:0]          len;
  } code_t;

  // Indexed by symbol + 8.
  localparam code_t CODE_TABLE [16] = '{
    {9'h0FF, 4'd8},  // -8
    {9'h17F, 4'd9},  // -7
    {9'h0BF, 4'd8},  // -6
    {9'h05F, 4'd7},  // -5
    {9'h02F, 4'd6},  // -4
    {9'h017, 4'd5},  // -3
    {9'h00B, 4'd4},  // -2
    {9'h005, 4'd3},  // -1
    {9'h000, 4'd1},  //  0
    {9'h001, 4'd3},  // +1
    {9'h003, 4'd4},  // +2
    {9'h007, 4'd5},  // +3
    {9'h00F, 4'd6},  // +4
    {9'h01F, 4'd7},  // +5
    {9'h03F, 4'd8},  // +6
    {9'h07F, 4'd9}   // +7
  };

  // symbol + 8 on a 4-bit two's complement value is just an MSB flip.
  function automatic code_t huff_lookup(input logic [3:0] sym);
    return CODE_TABLE[{~sym[3], sym[2:0]}];
  endfunction

endpackage

// File: rtl/huff_encoder_packer_if.sv
// huff_encoder_packer_if: symbol input, flush control, chunk output and
// status of the Huffman encoder/packer.
//   master : symbol/flush source and chunk sink (drives s_valid, s_symbol,
//            flush, out_ready)
//   slave  : the encoder (drives s_ready, flush_done, out_bits, out_len,
//            out_valid, bit_count)
interface huff_encoder_packer_if;

  logic              s_valid;
  logic signed [3:0] s_symbol;
  logic              s_ready;
  logic              flush;
  logic              flush_done;
  logic [3:0]        out_bits;
  logic [2:0]        out_len;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        bit_count;

  modport master (
    output s_valid, s_symbol, flush, out_ready,
    input  s_ready, flush_done, out_bits, out_len, out_valid, bit_count
  );

  modport slave (
    input  s_valid, s_symbol, flush, out_ready,
    output s_ready, flush_done, out_bits, out_len, out_valid, bit_count
  );

endinterface

// File: rtl/huff_code_lut.sv
// huff_code_lut: combinational symbol -> {code, len} map.
//   i_symbol : signed 4-bit symbol (-8..7)
//   o_code   : code bits, LSB transmitted first, unused high bits 0
//   o_len    : code length in bits (1..9)
module huff_code_lut
  import huff_pkg::*;
(
  input  logic [3:0]          i_symbol,
  output logic [MAX_CODE-1:0] o_code,
  output logic [3:0]          o_len
);

  code_t w_entry;

  assign w_entry = huff_lookup(i_symbol);
  assign o_code  = w_entry.code;
  assign o_len   = w_entry.len;

endmodule

// File: rtl/huff_encoder_packer.sv
// huff_encoder_packer: maps signed 4-bit symbols to prefix codes, packs them
// LSB-first into a bit accumulator and emits 1..4 bit chunks with a
// valid/ready handshake. A flush request drains the partial tail.
//   clk      : clock
//   reset    : asynchronous, active-high
//   io_bus   : huff_encoder_packer_if.slave (symbols in, chunks out, status)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | accept symbols, emit only full 4-bit chunks
// ST_FLUSH | no new symbols, emit whatever remains, then pulse flush_done
module huff_encoder_packer
  import huff_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  huff_encoder_packer_if.slave io_bus
);

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  // Room for a worst-case code without overflowing the accumulator.
  localparam logic [4:0] C_RDY_MAX = 5'(BUF_W - MAX_CODE);
  localparam logic [4:0] C_CHUNK   = 5'(CHUNK_W);

  logic             r_state;
  logic [BUF_W-1:0] r_acc;
  logic [4:0]       r_bit_count;
  logic [3:0]       r_out_bits;
  logic [2:0]       r_out_len;
  logic             r_out_valid;
  logic             r_flush_done;

  logic [MAX_CODE-1:0] w_code;
  logic [3:0]          w_len;
  logic                w_slot_free;
  logic                w_avail;
  logic                w_emit;
  logic [2:0]          w_emit_len;
  logic [3:0]          w_mask;
  logic                w_s_ready;
  logic                w_accept;
  logic [BUF_W-1:0]    w_acc_shift;
  logic [4:0]          w_bc_shift;
  logic [BUF_W-1:0]    w_code_ext;
  logic [BUF_W-1:0]    w_acc_next;
  logic [4:0]          w_bc_next;
  logic                w_flush_now;
  logic                w_flush_fin;

  huff_code_lut u_lut (
    .i_symbol (io_bus.s_symbol),
    .o_code   (w_code),
    .o_len    (w_len)
  );

  assign w_slot_free = !r_out_valid || io_bus.out_ready;
  assign w_avail     = (r_state == ST_RUN) ? (r_bit_count >= C_CHUNK)
                                           : (r_bit_count != 5'd0);
  assign w_emit      = w_slot_free && w_avail;
  assign w_emit_len  = !w_emit                  ? 3'd0 :
                       (r_bit_count >= C_CHUNK) ? 3'(CHUNK_W) :
                                                  r_bit_count[2:0];

  always_comb begin
    w_mask = 4'b0000;
    case (w_emit_len)
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      3'd3:    w_mask = 4'b0111;
      3'd4:    w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  // Gated by reset so the source sees not-ready while the block is held.
  assign w_s_ready = !reset && (r_state == ST_RUN) && (r_bit_count <= C_RDY_MAX);
  assign w_accept  = io_bus.s_valid && w_s_ready;

  // Emit shift happens first; the new code lands at the post-shift fill.
  assign w_acc_shift = r_acc >> w_emit_len;
  assign w_bc_shift  = r_bit_count - {2'b00, w_emit_len};
  assign w_code_ext  = {{(BUF_W-MAX_CODE){1'b0}}, w_code};
  assign w_acc_next  = w_accept ? (w_acc_shift | (w_code_ext << w_bc_shift))
                                : w_acc_shift;
  assign w_bc_next   = w_bc_shift + (w_accept ? {1'b0, w_len} : 5'd0);

  // Nothing buffered and nothing in flight: finish without entering FLUSH.
  assign w_flush_now = (r_state == ST_RUN) && io_bus.flush &&
                       (r_bit_count == 5'd0) && !r_out_valid && !w_accept;
  assign w_flush_fin = (r_state == ST_FLUSH) && (r_bit_count == 5'd0) &&
                       w_slot_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_acc        <= '0;
      r_bit_count  <= 5'd0;
      r_out_bits   <= 4'd0;
      r_out_len    <= 3'd0;
      r_out_valid  <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_acc        <= w_acc_next;
      r_bit_count  <= w_bc_next;
      r_flush_done <= 1'b0;

      if (w_emit) begin
        r_out_bits  <= r_acc[3:0] & w_mask;
        r_out_len   <= w_emit_len;
        r_out_valid <= 1'b1;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_RUN: begin
          if (io_bus.flush) begin
            if (w_flush_now) r_flush_done <= 1'b1;
            else             r_state      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_flush_fin) begin
            r_flush_done <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign io_bus.s_ready    = w_s_ready;
  assign io_bus.flush_done = r_flush_done;
  assign io_bus.out_bits   = r_out_bits;
  assign io_bus.out_len    = r_out_len;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.bit_count  = r_bit_count;

endmodule

// File: tb/tb_huff_encoder_packer.sv
// tb_huff_encoder_packer: scoreboard bench for huff_encoder_packer.
// Accepted symbols push their code bits (built from the code rules) into an
// expected bit queue; a negedge monitor pops and compares on every chunk
// handshake, and on each flush_done decodes the received stream and compares
// it with the symbols sent.
module tb_huff_encoder_packer;

  logic clk;
  logic reset;

  huff_encoder_packer_if bus ();

  huff_encoder_packer dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit   exp_q[$];
  bit   rx_q[$];
  int   sent_q[$];
  bit   flush_active = 0;
  bit   hold_v = 0;
  logic [3:0] hold_bits;
  logic [2:0] hold_len;
  bit   prev_fd = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   fd_cyc = 0;
  int   flush_done_cnt = 0;
  int   chunk_cnt = 0;
  logic [3:0] last_bits = 4'd0;
  logic [2:0] last_len = 3'd0;
  bit   rand_ready = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_code(input int sym);
    int k;
    if (sym == 0) begin
      exp_q.push_back(1'b0);
    end else if (sym == -8) begin
      repeat (8) exp_q.push_back(1'b1);
    end else begin
      k = (sym < 0) ? -sym : sym;
      repeat (k) exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      exp_q.push_back(sym < 0);
    end
  endtask

  // Decode the received LSB-first stream and compare it with the symbols sent.
  task automatic check_stream();
    int dec[$];
    int i = 0;
    int k;
    int errs = 0;
    while (i < rx_q.size()) begin
      k = 0;
      while (i < rx_q.size() && rx_q[i] == 1'b1 && k < 8) begin
        k++;
        i++;
      end
      if (k == 8) dec.push_back(-8);
      else if (i >= rx_q.size()) dec.push_back(99);
      else begin
        i++;
        if (k == 0) dec.push_back(0);
        else if (i >= rx_q.size()) dec.push_back(99);
        else begin
          dec.push_back(rx_q[i] ? -k : k);
          i++;
        end
      end
    end
    check("stream_count", dec.size(), sent_q.size());
    for (int j = 0; j < dec.size() && j < sent_q.size(); j++)
      if (dec[j] != sent_q[j]) errs++;
    check("stream_symbols", errs, 0);
    rx_q.delete();
    sent_q.delete();
  endtask

  always @(negedge clk) begin
    int pend;
    int n;
    int under;
    logic [3:0] exp_chunk;
    cyc++;
    if (reset) begin
      exp_q.delete();
      rx_q.delete();
      sent_q.delete();
      flush_active = 0;
      hold_v = 0;
      prev_fd = 0;
    end else begin
      if (bus.flush_done) begin
        check("flush_done_pulse", int'(prev_fd), 0);
        flush_done_cnt++;
        fd_cyc = cyc;
        flush_active = 0;
        check("flush_drained", exp_q.size(), 0);
        check_stream();
      end
      prev_fd = bus.flush_done;

      pend = exp_q.size() - (bus.out_valid ? int'(bus.out_len) : 0);
      check("bit_count", int'(bus.bit_count), pend);
      check("bit_count_overflow", int'(bus.bit_count > 5'd16), 0);
      check("s_ready", int'(bus.s_ready), int'(!flush_active && pend <= 7));

      if (hold_v) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_bits", int'(bus.out_bits), int'(hold_bits));
        check("hold_len", int'(bus.out_len), int'(hold_len));
      end
      hold_v    = bus.out_valid && !bus.out_ready;
      hold_bits = bus.out_bits;
      hold_len  = bus.out_len;

      if (bus.out_valid && bus.out_ready) begin
        n = (bus.out_len > 3'd4) ? 4 : int'(bus.out_len);
        exp_chunk = 4'd0;
        under = 0;
        for (int i = 0; i < n; i++) begin
          if (exp_q.size() > 0) exp_chunk[i] = exp_q.pop_front();
          else under++;
        end
        check("chunk_bits", int'(bus.out_bits), int'(exp_chunk));
        check("chunk_underflow", under, 0);
        check("chunk_len_range", int'(bus.out_len >= 3'd1 && bus.out_len <= 3'd4), 1);
        if (!flush_active) check("chunk_len_run", int'(bus.out_len), 4);
        for (int i = 0; i < n; i++) rx_q.push_back(bus.out_bits[i]);
        chunk_cnt++;
        last_bits = bus.out_bits;
        last_len  = bus.out_len;
        hs_cyc    = cyc;
      end

      if (bus.s_valid && bus.s_ready) begin
        push_code(int'(bus.s_symbol));
        sent_q.push_back(int'(bus.s_symbol));
      end

      if (bus.flush && !flush_active) flush_active = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_sym(input int sym);
    bit acc = 0;
    bus.s_valid  = 1'b1;
    bus.s_symbol = 4'(sym);
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = bus.s_ready;
      tick();
    end
    bus.s_valid = 1'b0;
    if (!acc) check("accept_timeout", int'(acc), 1);
  endtask

  task automatic do_flush();
    int start = flush_done_cnt;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 500 && flush_done_cnt == start; i++) tick();
    check("flush_done_seen", flush_done_cnt - start, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int s;
    reset         = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_symbol  = 4'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_s_ready", int'(bus.s_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_bits", int'(bus.out_bits), 0);
    check("rst_out_len", int'(bus.out_len), 0);
    check("rst_bit_count", int'(bus.bit_count), 0);
    check("rst_flush_done", int'(bus.flush_done), 0);
    reset = 1'b0;
    tick();

    // Four zeros -> one 0000/4 chunk.
    bus.out_ready = 1'b1;
    base = chunk_cnt;
    repeat (4) send_sym(0);
    repeat (3) tick();
    check("t1_chunks", chunk_cnt - base, 1);
    check("t1_bits", int'(last_bits), 0);
    check("t1_len", int'(last_len), 4);
    check("t1_bit_count", int'(bus.bit_count), 0);

    // +1 then 0 -> stream 1,0,0,0.
    base = chunk_cnt;
    send_sym(1);
    send_sym(0);
    repeat (3) tick();
    check("t2_chunks", chunk_cnt - base, 1);
    check("t2_bits", int'(last_bits), 1);
    check("t2_len", int'(last_len), 4);

    // -1 then flush -> 101 as a 3-bit chunk.
    base = chunk_cnt;
    send_sym(-1);
    do_flush();
    check("t3_chunks", chunk_cnt - base, 1);
    check("t3_bits", int'(last_bits), 5);
    check("t3_len", int'(last_len), 3);
    check("t3_done_latency", fd_cyc - hs_cyc, 1);

    // -8 with a stalled sink: chunk held, then a second one after release.
    bus.out_ready = 1'b0;
    base = chunk_cnt;
    send_sym(-8);
    repeat (5) tick();
    check("t4_held_valid", int'(bus.out_valid), 1);
    check("t4_held_bits", int'(bus.out_bits), 15);
    check("t4_held_len", int'(bus.out_len), 4);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("t4_chunks", chunk_cnt - base, 2);
    check("t4_bits", int'(last_bits), 15);
    check("t4_bit_count", int'(bus.bit_count), 0);

    // Back-to-back +7.
    repeat (10) send_sym(7);
    do_flush();

    // Reset with 6 bits buffered and a chunk stuck in the output slot.
    bus.out_ready = 1'b0;
    send_sym(-8);
    send_sym(0);
    send_sym(0);
    tick();
    check("t6_pre_bit_count", int'(bus.bit_count), 6);
    check("t6_pre_valid", int'(bus.out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", int'(bus.out_valid), 0);
    check("t6_rst_bit_count", int'(bus.bit_count), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    base = chunk_cnt;
    send_sym(0);
    do_flush();
    check("t6_chunks", chunk_cnt - base, 1);
    check("t6_len", int'(last_len), 1);
    check("t6_bits", int'(last_bits), 0);

    // Random symbols, random sink stalls, occasional flushes.
    rand_ready = 1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      s = int'($urandom_range(0, 15)) - 8;
      send_sym(s);
      if ($urandom_range(0, 39) == 0) do_flush();
    end
    do_flush();
    rand_ready = 0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
